dadd_result_buffer: RTL and testbench

Downstream stage of the dadd datapath. It captures every result the dadd block emits on its output strobe (dadd_out_en, dadd_out_addr, dadd_out) into a DEPTH-entry FIFO of {addr, data} pairs. It presents those pairs to a consumer over a valid/ready handshake. Because the dadd output has no backpressure, the block also reports occupancy and overflow, and counts dropped results.

---
 rtl/dadd_result_buffer.sv | 141 ++++++++++++++
 tb/tb_dadd_result_buffer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dadd_result_buffer.sv
// dadd_result_buffer: captures every dadd result strobe into a DEPTH-entry
// FIFO of {addr, data} pairs and presents the head to a consumer over a
// valid/ready handshake. The producer cannot be stalled, so the block also
// reports occupancy and a sticky overflow flag, and counts dropped results.
module dadd_result_buffer #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          dadd_out_en,
    input  logic [31:0]   dadd_out_addr,
    input  logic [31:0]   dadd_out,
    output logic          rslt_valid,
    input  logic          rslt_ready,
    output logic [31:0]   rslt_addr,
    output logic [31:0]   rslt_data,
    output logic [AW:0]   level,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    output logic [15:0]   drop_cnt,
    input  logic          clr_ovf
);

    localparam int          PTR_W     = AW + 1;
    localparam logic [AW:0] DEPTH_L   = PTR_W'(DEPTH);
    localparam logic [AW:0] PTR_ONE   = PTR_W'(1);
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    // Storage carries no reset: entries are only meaningful between pointers.
    logic [63:0]  mem_q [DEPTH];

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         overflow_q, overflow_d;
    logic [15:0]  drop_cnt_q, drop_cnt_d;

    logic [AW:0]  level_s;
    logic         empty_s;
    logic         full_s;
    logic         pop_s;
    logic         push_s;
    logic         drop_s;
    logic [63:0]  head_s;

    // Occupancy and handshake qualifiers derived from the registered pointers.
    always_comb begin
        level_s = wr_ptr_q - rd_ptr_q;
        empty_s = (level_s == {PTR_W{1'b0}});
        full_s  = (level_s == DEPTH_L);
        pop_s   = (!empty_s) && rslt_ready;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts.
        push_s  = dadd_out_en && ((!full_s) || pop_s);
        drop_s  = dadd_out_en && full_s && (!pop_s);
    end

    // Next-state for pointers, sticky overflow flag and saturating drop count.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        // A drop coinciding with a clear wins: the flag stays set, count restarts at 1.
        if (drop_s) begin
            overflow_d = 1'b1;
            if (clr_ovf) begin
                drop_cnt_d = 16'd1;
            end else if (drop_cnt_q != CNT_MAX) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
            drop_cnt_d = 16'd0;
        end else begin
            overflow_d = overflow_q;
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Control state registers, cleared asynchronously on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            overflow_q <= 1'b0;
            drop_cnt_q <= 16'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Result storage write port; the index drops the pointer wrap bit.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {dadd_out_addr, dadd_out};
        end
    end

    // Show-ahead head of the FIFO, forced to zero while nothing is queued.
    always_comb begin
        head_s = mem_q[rd_ptr_q[AW-1:0]];
        if (empty_s) begin
            rslt_valid = 1'b0;
            rslt_addr  = 32'd0;
            rslt_data  = 32'd0;
        end else begin
            rslt_valid = 1'b1;
            rslt_addr  = head_s[63:32];
            rslt_data  = head_s[31:0];
        end
    end

    // Status outputs straight from registered state.
    always_comb begin
        level    = level_s;
        empty    = empty_s;
        full     = full_s;
        overflow = overflow_q;
        drop_cnt = drop_cnt_q;
    end

endmodule

// File: tb/tb_dadd_result_buffer.sv
// Testbench for dadd_result_buffer: a table of {inputs, expected status}
// records plus hand-written sequences; a scoreboard queue of expected
// {addr, data} pairs checks every head value and the delivery order.
module tb_dadd_result_buffer;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk;
    logic          reset_n;
    logic          dadd_out_en;
    logic [31:0]   dadd_out_addr;
    logic [31:0]   dadd_out;
    logic          rslt_valid;
    logic          rslt_ready;
    logic [31:0]   rslt_addr;
    logic [31:0]   rslt_data;
    logic [AW:0]   level;
    logic          empty;
    logic          full;
    logic          overflow;
    logic [15:0]   drop_cnt;
    logic          clr_ovf;

    dadd_result_buffer #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .dadd_out_en   (dadd_out_en),
        .dadd_out_addr (dadd_out_addr),
        .dadd_out      (dadd_out),
        .rslt_valid    (rslt_valid),
        .rslt_ready    (rslt_ready),
        .rslt_addr     (rslt_addr),
        .rslt_data     (rslt_data),
        .level         (level),
        .empty         (empty),
        .full          (full),
        .overflow      (overflow),
        .drop_cnt      (drop_cnt),
        .clr_ovf       (clr_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        en;
        logic [31:0] addr;
        logic [31:0] data;
        logic        rdy;
        logic        clr;
        int          exp_level;
        logic        exp_full;
        logic        exp_ovf;
        int          exp_cnt;
    } vec_t;

    vec_t        tbl [40];
    int          n_vec;
    int          checks;
    int          failures;
    logic [63:0] mq [$];
    logic        m_ovf;
    int          m_cnt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic en, input logic [31:0] a, input logic [31:0] d,
                       input logic rdy, input logic clr, input int lvl,
                       input logic fl, input logic ov, input int cnt);
        tbl[n_vec].en        = en;
        tbl[n_vec].addr      = a;
        tbl[n_vec].data      = d;
        tbl[n_vec].rdy       = rdy;
        tbl[n_vec].clr       = clr;
        tbl[n_vec].exp_level = lvl;
        tbl[n_vec].exp_full  = fl;
        tbl[n_vec].exp_ovf   = ov;
        tbl[n_vec].exp_cnt   = cnt;
        n_vec++;
    endtask

    // One clock: entered at posedge+1, drives inputs, checks the DUT against
    // the scoreboard just before the edge, updates the model, returns at posedge+1.
    task automatic step(input logic en, input logic [31:0] a, input logic [31:0] d,
                        input logic rdy, input logic clr);
        logic m_full;
        logic m_pop;
        dadd_out_en   = en;
        dadd_out_addr = a;
        dadd_out      = d;
        rslt_ready    = rdy;
        clr_ovf       = clr;
        #3;
        chk("valid", {63'd0, rslt_valid}, {63'd0, mq.size() != 0});
        if (mq.size() != 0) begin
            chk("head_addr", {32'd0, rslt_addr}, {32'd0, mq[0][63:32]});
            chk("head_data", {32'd0, rslt_data}, {32'd0, mq[0][31:0]});
        end else begin
            chk("idle_addr", {32'd0, rslt_addr}, 64'd0);
            chk("idle_data", {32'd0, rslt_data}, 64'd0);
        end
        chk("level", {60'd0, level}, 64'(mq.size()));
        chk("empty", {63'd0, empty}, {63'd0, mq.size() == 0});
        chk("full", {63'd0, full}, {63'd0, mq.size() == DEPTH});
        chk("overflow", {63'd0, overflow}, {63'd0, m_ovf});
        chk("drop_cnt", {48'd0, drop_cnt}, 64'(m_cnt));

        m_full = (mq.size() == DEPTH);
        m_pop  = (mq.size() != 0) && rdy;
        if (m_pop) void'(mq.pop_front());
        if (en && (!m_full || m_pop)) mq.push_back({a, d});
        if (en && m_full && !m_pop) begin
            m_ovf = 1'b1;
            if (clr) m_cnt = 1;
            else if (m_cnt != 65535) m_cnt = m_cnt + 1;
        end else if (clr) begin
            m_ovf = 1'b0;
            m_cnt = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_valid"}, {63'd0, rslt_valid}, 64'd0);
        chk({tag, "_addr"}, {32'd0, rslt_addr}, 64'd0);
        chk({tag, "_data"}, {32'd0, rslt_data}, 64'd0);
        chk({tag, "_level"}, {60'd0, level}, 64'd0);
        chk({tag, "_empty"}, {63'd0, empty}, 64'd1);
        chk({tag, "_full"}, {63'd0, full}, 64'd0);
        chk({tag, "_ovf"}, {63'd0, overflow}, 64'd0);
        chk({tag, "_cnt"}, {48'd0, drop_cnt}, 64'd0);
    endtask

    initial begin
        checks = 0; failures = 0; n_vec = 0;
        m_ovf = 1'b0; m_cnt = 0;
        reset_n = 1'b0; dadd_out_en = 1'b0; dadd_out_addr = 32'd0;
        dadd_out = 32'd0; rslt_ready = 1'b0; clr_ovf = 1'b0;

        // Single push held until accepted, ready while empty, fill, drop,
        // push+pop while full, then drain (9 must come out last).
        add(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 1, 1'b0, 1'b0, 0);
        add(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 0);
        add(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 0);
        add(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0);
        add(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0);
        for (int i = 1; i <= 8; i++)
            add(1'b1, 32'h100 + 32'(i), 32'(i), 1'b0, 1'b0, i, (i == 8), 1'b0, 0);
        add(1'b1, 32'h1FF, 32'd99, 1'b0, 1'b0, 8, 1'b1, 1'b1, 1);
        add(1'b1, 32'h109, 32'd9, 1'b1, 1'b0, 8, 1'b1, 1'b1, 1);
        for (int k = 0; k < 8; k++)
            add(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 7 - k, 1'b0, 1'b1, 1);

        #12;
        chk_reset_values("rst");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < n_vec; v++) begin
            step(tbl[v].en, tbl[v].addr, tbl[v].data, tbl[v].rdy, tbl[v].clr);
            chk($sformatf("vec%0d_level", v), {60'd0, level}, 64'(tbl[v].exp_level));
            chk($sformatf("vec%0d_full", v), {63'd0, full}, {63'd0, tbl[v].exp_full});
            chk($sformatf("vec%0d_ovf", v), {63'd0, overflow}, {63'd0, tbl[v].exp_ovf});
            chk($sformatf("vec%0d_cnt", v), {48'd0, drop_cnt}, 64'(tbl[v].exp_cnt));
        end

        // Clear the sticky flag, then stream 40 results with the consumer always ready.
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("clr_ovf", {63'd0, overflow}, 64'd0);
        chk("clr_cnt", {48'd0, drop_cnt}, 64'd0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 32'h2000 + 32'(i), 32'hA000_0000 + 32'(i), 1'b1, 1'b0);
            chk("stream_level_le1", {63'd0, level <= 4'd1}, 64'd1);
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("stream_drained", {63'd0, empty}, 64'd1);

        // Fill, three drops, then a clear coinciding with a drop.
        for (int i = 0; i < 8; i++)
            step(1'b1, 32'h300 + 32'(i), 32'h30 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h3FF, 32'hBAD0 + 32'(i), 1'b0, 1'b0);
        chk("three_drops", {48'd0, drop_cnt}, 64'd3);
        step(1'b1, 32'h3FF, 32'hBAD9, 1'b0, 1'b1);
        chk("clr_drop_ovf", {63'd0, overflow}, 64'd1);
        chk("clr_drop_cnt", {48'd0, drop_cnt}, 64'd1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Drain to five entries, then reset asynchronously mid-cycle.
        for (int i = 0; i < 3; i++)
            step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("pre_reset_level", {60'd0, level}, 64'd5);
        dadd_out_en = 1'b1; dadd_out_addr = 32'h777; dadd_out = 32'h777; rslt_ready = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        chk_reset_values("midrst");
        dadd_out_en = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        m_cnt = 0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 32'hABC, 32'h1234_5678, 1'b0, 1'b0);
        chk("post_reset_level", {60'd0, level}, 64'd1);
        chk("post_reset_addr", {32'd0, rslt_addr}, 64'hABC);
        chk("post_reset_data", {32'd0, rslt_data}, 64'h1234_5678);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
